chunked_serial_adder: RTL and testbench
=======================================

# chunked_serial_adder

- Multi-cycle, parametrised WIDTH-bit adder/subtractor with valid/ready handshakes.
- Processes CHUNK bits per cycle through one CHUNK-bit ripple stage, registering the carry between cycles.
- Trades latency for area: one small adder is reused over WIDTH/CHUNK cycles instead of instantiating a full-width ripple chain.
- Sits between an operand producer and a result consumer, and adds subtract mode and signed-overflow detection.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands and mode presented.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; add mode only.
- sub  in  1  0 selects a+b+cin; 1 selects a−b, with cin ignored.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB; in sub mode, 1 means no borrow.
- overflow  out  1  two's-complement signed overflow.

## Operation
- NCHUNK = WIDTH/CHUNK.
- Three-state FSM:
  - IDLE: in_ready=1.
  - BUSY: chunk index k counts 0..NCHUNK−1.
  - DONE: out_valid=1.
- Accept occurs when in_valid&&in_ready. On accept:
  - Latch a.
  - Latch b, or ~b when sub=1.
  - Load the carry register with cin (add) or 1 (sub).
  - Set k=0 and go to BUSY.
- BUSY, each cycle:
  - Chunk k = a[k*CHUNK +: CHUNK] + b'[k*CHUNK +: CHUNK] + carry.
  - Write the chunk result into sum[k*CHUNK +: CHUNK] and register the chunk carry-out.
  - Increment k.
  - When k=NCHUNK−1, go to DONE. At that point:
    - cout = final carry.
    - overflow = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]).
- DONE:
  - sum/cout/overflow hold stable until out_valid&&out_ready.
  - On that handshake, go to IDLE.
  - Exception: if in_valid is also high in the same cycle, accept the new operands directly and go to BUSY, giving back-to-back operation.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational from out_ready.
- Operands on a/b/cin/sub are sampled only at accept and may change freely afterwards.
- Reset (any state, including mid-BUSY):
  - Next state IDLE.
  - sum=0, cout=0, overflow=0, out_valid=0, k=0, carry register=0.
  - Any in-flight operation is discarded with no partial result.
- CHUNK=WIDTH is legal: NCHUNK=1 and BUSY lasts one cycle.

## Timing
- Accept at edge E0.
- Chunks 0..NCHUNK−1 are computed at edges E1..E_NCHUNK.
- out_valid rises after E_NCHUNK, i.e. latency NCHUNK cycles from accept.
- Throughput: one result per NCHUNK+1 cycles if the consumer acks in the first DONE cycle and a new operand is accepted then. A held-off consumer stalls the block indefinitely.
- Output values:
  - sum/cout/overflow are don't-care while out_valid=0, except after reset, when they are 0.
  - All outputs are registered except in_ready.
- Critical path: one CHUNK-bit ripple chain plus the carry mux.

## Structure
- Shared package (csa_pkg):
  - FSM state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - Helper function for the chunk count.
- Sub-module chunk_adder: combinational, parametrised CHUNK-bit ripple stage built from the team's existing full_adder cell.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and carry into the MSB (available for debug/overflow cross-check).
- Top level holds the FSM, chunk counter (width $clog2(NCHUNK)+1), operand registers, carry register and result register.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- Add, a=0x1234, b=0x0FFF, cin=0, sub=0: expect sum=0x2233, cout=0, overflow=0. out_valid must rise exactly 4 cycles after accept.
- Full carry ripple across all chunks, a=0xFFFF, b=0x0001, cin=0: expect sum=0x0000, cout=1, overflow=0.
- Subtract, a=0x8000, b=0x0001, sub=1, cin=1: cin must be ignored. Expect sum=0x7FFF, cout=1, overflow=1.
- Signed overflow with carry-in, a=0x7FFF, b=0x0000, cin=1: expect sum=0x8000, cout=0, overflow=1.
- Backpressure, then back-to-back:
  - Hold out_ready=0 for 3 DONE cycles: outputs and out_valid must stay stable and in_ready=0.
  - Then raise out_ready with in_valid=1, a=0x0001, b=0x0002: same-cycle accept. Next out_valid comes 4 cycles later with sum=0x0003.
- Reset mid-operation: assert rst for one cycle during the 2nd BUSY cycle. Next cycle expect out_valid=0, in_ready=1, sum=0. A subsequent operation must complete with a correct result.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the chunked serial adder: FSM encoding and chunk-count helper.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry stage; also exposes the carry into its MSB for overflow detection.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell, the building block of the chunk ripple stage.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor reusing one CHUNK-bit ripple stage, with valid/ready handshakes.
module chunked_serial_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int KW     = $clog2(NCHUNK) + 1;
    localparam logic [KW-1:0] LAST = KW'(NCHUNK - 1);

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_chunk;
    logic             c_msb;
    logic             accept;

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    assign a_chunk = a_reg[k*CHUNK +: CHUNK];
    assign b_chunk = b_reg[k*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry),
        .sum   (s_chunk),
        .cout  (c_chunk),
        .c_msb (c_msb)
    );

    // Subtraction is a + ~b + 1, so the operand is inverted and the carry seeded with 1 at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= sub ? ~b : b;
            carry     <= sub | cin;
            k         <= '0;
            out_valid <= 1'b0;
            state     <= BUSY;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                BUSY: begin
                    sum[k*CHUNK +: CHUNK] <= s_chunk;
                    carry                 <= c_chunk;
                    k                     <= k + 1'b1;
                    // Carry into vs. out of the MSB differing is exactly signed overflow.
                    if (k == LAST) begin
                        cout      <= c_chunk;
                        overflow  <= c_chunk ^ c_msb;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard-driven bench for chunked_serial_adder at WIDTH=16, CHUNK=4.
module tb_chunked_serial_adder;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             v;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    chunked_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow)
    );

    // Full-width reference: one wide addition, signed overflow from operand and result signs.
    function automatic exp_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mc, input logic ms);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        exp_t             e;
        bb   = ms ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{WIDTH{1'b0}}, (ms ? 1'b1 : mc)};
        e.s  = full[WIDTH-1:0];
        e.c  = full[WIDTH];
        e.v  = (ma[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ma[WIDTH-1]);
        return e;
    endfunction

    task automatic scramble_inputs();
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom);
        sub = 1'($urandom);
    endtask

    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ic, input logic is, output bit took);
        a        = ia;
        b        = ib;
        cin      = ic;
        sub      = is;
        in_valid = 1'b1;
        took     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                took = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (took) begin
            sb.push_back(model(ia, ib, ic, is));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid === 1'b1) break;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = '0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL reset_handshake: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        vectors++;
        if ({sum, cout, overflow} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got sum=%h cout=%b ovf=%b expected 0000 0 0", sum, cout, overflow);
        end
    endtask

    task automatic test_vector(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                               input logic tc, input logic ts);
        bit   took;
        int   cyc;
        exp_t e;
        issue(ta, tb_, tc, ts, took);
        wait_out(cyc);
        vectors++;
        if (!took || cyc != NCHUNK || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL %s_latency: got took=%0b cycles=%0d out_valid=%b expected took=1 cycles=%0d out_valid=1",
                     name, took, cyc, out_valid, NCHUNK);
        end
        pop_exp(e);
        vectors++;
        if ({sum, cout, overflow} !== {e.s, e.c, e.v}) begin
            miscompares++;
            $display("[TB] FAIL %s_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     name, sum, cout, overflow, e.s, e.c, e.v);
        end
        consume();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL %s_release: got out_valid=%b in_ready=%b expected 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_add();
        test_vector("add", 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    endtask

    task automatic test_carry_ripple();
        test_vector("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    endtask

    task automatic test_sub();
        test_vector("sub", 16'h8000, 16'h0001, 1'b1, 1'b1);
    endtask

    task automatic test_overflow_cin();
        test_vector("ovf_cin", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit               took;
        int               cyc;
        exp_t             e;
        logic [WIDTH+1:0] hold;
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, took);
        wait_out(cyc);
        vectors++;
        if (!took || cyc != NCHUNK) begin
            miscompares++;
            $display("[TB] FAIL bp_latency: got took=%0b cycles=%0d expected took=1 cycles=%0d", took, cyc, NCHUNK);
        end
        hold = {sum, cout, overflow};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, cout, overflow} !== hold) begin
                miscompares++;
                $display("[TB] FAIL bp_hold%0d: got out_valid=%b in_ready=%b out=%h expected 1 0 %h",
                         i, out_valid, in_ready, {sum, cout, overflow}, hold);
            end
        end
        pop_exp(e);
        vectors++;
        if ({sum, cout, overflow} !== {e.s, e.c, e.v}) begin
            miscompares++;
            $display("[TB] FAIL bp_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     sum, cout, overflow, e.s, e.c, e.v);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a         = 16'h0001;
        b         = 16'h0002;
        cin       = 1'b0;
        sub       = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_ready: got in_ready=%b expected 1", in_ready);
        end
        sb.push_back(model(16'h0001, 16'h0002, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        scramble_inputs();
        vectors++;
        if ({out_valid, in_ready} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL b2b_busy: got out_valid=%b in_ready=%b expected 0 0", out_valid, in_ready);
        end
        wait_out(cyc);
        vectors++;
        if (cyc != NCHUNK || out_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_latency: got cycles=%0d out_valid=%b expected cycles=%0d out_valid=1",
                     cyc, out_valid, NCHUNK);
        end
        pop_exp(e);
        vectors++;
        if ({sum, cout, overflow} !== {e.s, e.c, e.v}) begin
            miscompares++;
            $display("[TB] FAIL b2b_result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     sum, cout, overflow, e.s, e.c, e.v);
        end
        consume();
    endtask

    task automatic test_reset_mid_op();
        bit took;
        issue(16'hAAAA, 16'h5555, 1'b1, 1'b0, took);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        vectors++;
        if (!took || {out_valid, in_ready} !== 2'b01 || {sum, cout, overflow} !== '0) begin
            miscompares++;
            $display("[TB] FAIL midrst_state: got took=%0b out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b expected 1 0 1 0000 0 0",
                     took, out_valid, in_ready, sum, cout, overflow);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL midrst_quiet%0d: got out_valid=%b expected 0", i, out_valid);
            end
        end
        test_vector("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            test_vector("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_ripple();
        test_sub();
        test_overflow_cin();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
